// File: rtl/train_render_if.sv
// Bundle between the train controller and the VGA renderer: train centre positions in, video out.
// master = controller/display side, slave = train_render.
interface train_render_if;
  logic [9:0]  Ax;
  logic [9:0]  Ay;
  logic [9:0]  Bx;
  logic [9:0]  By;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [11:0] rgb;
  logic        frame_start;
  logic        collision;

  modport master (
    output Ax, Ay, Bx, By,
    input  hsync, vsync, video_on, rgb, frame_start, collision
  );

  modport slave (
    input  Ax, Ay, Bx, By,
    output hsync, vsync, video_on, rgb, frame_start, collision
  );
endinterface

// File: rtl/train_render.sv
// 640x480@60 VGA renderer for two train squares on an oval double track.
// Optional macro TRAIN_RENDER_COLLISION_EN: overlap pixels drawn white and a per-frame collision flag.
`default_nettype none
module train_render #(
  parameter int TRAIN_HALF = 8,
  parameter int TRACK_HALF = 1
) (
  input  logic          clk,
  input  logic          rst,
  train_render_if.slave bus
);
  localparam logic [9:0] H_MAX = 10'd799;
  localparam logic [9:0] V_MAX = 10'd524;

  // Track rectangles, index 0 = outer, 1 = inner.
  localparam logic [1:0][9:0] RECT_X0 = {10'd188, 10'd60};
  localparam logic [1:0][9:0] RECT_X1 = {10'd452, 10'd580};
  localparam logic [1:0][9:0] RECT_Y0 = {10'd180, 10'd60};
  localparam logic [1:0][9:0] RECT_Y1 = {10'd422, 10'd422};

  logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
  logic [9:0]  sax_q, sax_d, say_q, say_d, sbx_q, sbx_d, sby_q, sby_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic        frame_start_q, frame_start_d;
  logic [11:0] rgb_q, rgb_d;
  logic        latch, visible, in_a, in_b;
  logic [1:0]  on_rect_hit;

  // Lower bound clips at 0; upper bound kept unsigned in 11 bits so it never wraps.
  function automatic logic [10:0] box_lo(input logic [9:0] c);
    logic signed [10:0] lo;
    lo = $signed({1'b0, c}) - $signed(11'(TRAIN_HALF));
    return lo[10] ? 11'd0 : $unsigned(lo);
  endfunction

  function automatic logic [10:0] box_hi(input logic [9:0] c);
    return {1'b0, c} + 11'(TRAIN_HALF - 1);
  endfunction

  function automatic logic in_span(input logic [9:0] p, input logic [10:0] lo, input logic [10:0] hi);
    return ({1'b0, p} >= lo) && ({1'b0, p} <= hi);
  endfunction

  function automatic logic near(input logic [9:0] p, input logic [9:0] e);
    return ({1'b0, p} + 11'(TRACK_HALF) >= {1'b0, e}) && ({1'b0, p} <= {1'b0, e} + 11'(TRACK_HALF));
  endfunction

  function automatic logic on_rect(input logic [9:0] x, input logic [9:0] y, input logic [9:0] x0,
                                   input logic [9:0] x1, input logic [9:0] y0, input logic [9:0] y1);
    return ((x >= x0) && (x <= x1) && (near(y, y0) || near(y, y1))) ||
           ((y >= y0) && (y <= y1) && (near(x, x0) || near(x, x1)));
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_track
    assign on_rect_hit[gi] = on_rect(hcount_q, vcount_q, RECT_X0[gi], RECT_X1[gi],
                                     RECT_Y0[gi], RECT_Y1[gi]);
  end

  assign latch   = (hcount_q == 10'd0) && (vcount_q == 10'd480);
  assign visible = (hcount_q < 10'd640) && (vcount_q < 10'd480);
  assign in_a    = in_span(hcount_q, box_lo(sax_q), box_hi(sax_q)) &&
                   in_span(vcount_q, box_lo(say_q), box_hi(say_q));
  assign in_b    = in_span(hcount_q, box_lo(sbx_q), box_hi(sbx_q)) &&
                   in_span(vcount_q, box_lo(sby_q), box_hi(sby_q));

  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_MAX) begin
      hcount_d = 10'd0;
      vcount_d = (vcount_q == V_MAX) ? 10'd0 : vcount_q + 10'd1;
    end

    sax_d = latch ? bus.Ax : sax_q;
    say_d = latch ? bus.Ay : say_q;
    sbx_d = latch ? bus.Bx : sbx_q;
    sby_d = latch ? bus.By : sby_q;

    hsync_d       = !((hcount_q >= 10'd656) && (hcount_q <= 10'd751));
    vsync_d       = !((vcount_q >= 10'd490) && (vcount_q <= 10'd491));
    video_on_d    = visible;
    frame_start_d = (hcount_q == 10'd0) && (vcount_q == 10'd0);

    rgb_d = 12'h000;
    if (visible) begin
`ifdef TRAIN_RENDER_COLLISION_EN
      if (in_a && in_b)       rgb_d = 12'hFFF;
      else if (in_a)          rgb_d = 12'hF00;
`else
      if (in_a)               rgb_d = 12'hF00;
`endif
      else if (in_b)          rgb_d = 12'h00F;
      else if (|on_rect_hit)  rgb_d = 12'h888;
      else                    rgb_d = 12'h031;
    end
  end

`ifdef TRAIN_RENDER_COLLISION_EN
  logic collision_q, collision_d, overlap_in;

  // Judged on the values being latched, so the flag describes the frame about to be drawn.
  assign overlap_in = (box_lo(bus.Ax) <= box_hi(bus.Bx)) && (box_lo(bus.Bx) <= box_hi(bus.Ax)) &&
                      (box_lo(bus.Ay) <= box_hi(bus.By)) && (box_lo(bus.By) <= box_hi(bus.Ay));

  always_comb begin
    collision_d = latch ? overlap_in : collision_q;
  end

  always_ff @(posedge clk) begin
    if (rst) collision_q <= 1'b0;
    else     collision_q <= collision_d;
  end

  assign bus.collision = collision_q;
`else
  assign bus.collision = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      sax_q         <= 10'd320;
      say_q         <= 10'd60;
      sbx_q         <= 10'd320;
      sby_q         <= 10'd180;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= 12'h000;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      sax_q         <= sax_d;
      say_q         <= say_d;
      sbx_q         <= sbx_d;
      sby_q         <= sby_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.video_on    = video_on_q;
  assign bus.rgb         = rgb_q;
  assign bus.frame_start = frame_start_q;
endmodule
`default_nettype wire

// File: doc/train_render.md
TRAIN_RENDER -- requirements
Module: train_render

Interface
REQ-001 SHALL have parameter TRAIN_HALF, default 8: half-size of each train square, in pixels.
REQ-002 SHALL have parameter TRACK_HALF, default 1: half-thickness of track lines, in pixels.
REQ-003 SHALL have port clk, input, 1 bit: 25 MHz pixel clock; it is the only clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports Ax, Ay, Bx, By, input, 10 bits each: train A/B centre positions from the train controller.
REQ-006 SHALL have ports hsync and vsync, output, 1 bit each: VGA sync, active low.
REQ-007 SHALL have port video_on, output, 1 bit: high inside the 640x480 visible area.
REQ-008 SHALL have port rgb, output, 12 bits: pixel colour, 4:4:4 as R[11:8], G[7:4], B[3:0].
REQ-009 SHALL have port frame_start, output, 1 bit: one-cycle pulse on the first visible pixel of each frame.
REQ-010 SHALL have port collision, output, 1 bit: high while the two train squares overlap (latched per frame).

Function
REQ-011 SHALL keep hcount, 10 bits, counting 0..799 and wrapping to 0; vcount SHALL advance by one when hcount wraps, counting 0..524 and wrapping to 0.
REQ-012 Horizontal timing SHALL be 640 visible, 16 front porch, 96 sync (hcount 656..751), 48 back porch.
REQ-013 Vertical timing SHALL be 480 visible, 10 front porch, 2 sync (vcount 490..491), 33 back porch.
REQ-014 hsync, vsync, video_on, rgb and frame_start SHALL be registered and all aligned to the counter values of the previous cycle, giving one cycle of latency.
REQ-015 Ax, Ay, Bx and By SHALL be copied into shadow registers only when hcount==0 and vcount==480; drawing SHALL use only the shadow copies, so there is no tearing mid-frame.
REQ-016 Train A box SHALL cover x in [sAx-TRAIN_HALF, sAx+TRAIN_HALF-1] and y in [sAy-TRAIN_HALF, sAy+TRAIN_HALF-1]; train B box SHALL use the same rule.
REQ-017 Box bounds SHALL be computed with 11-bit signed arithmetic; a negative lower bound SHALL clip to 0, and no bound SHALL wrap.
REQ-018 The outer track SHALL be the perimeter of rectangle x 60..580, y 60..422; the inner track SHALL be the perimeter of x 188..452, y 180..422.
REQ-019 A pixel SHALL be on a track when it is within TRACK_HALF of a perimeter edge and inside that edge's span.
REQ-020 Colour priority SHALL be: not video_on -> 000; overlap pixel (REQ-026) -> FFF; train A -> F00; train B -> 00F; track -> 888; background -> 031.
REQ-021 frame_start SHALL be high for exactly one cycle per 420000 cycles.

Reset
REQ-022 Reset SHALL take effect on the clk edge where rst=1 and SHALL override all other behaviour.
REQ-023 On reset, hcount and vcount SHALL be 0, hsync and vsync 1, video_on 0, rgb 000, frame_start 0 and collision 0.
REQ-024 On reset, the shadow registers SHALL be sAx=320, sAy=60, sBx=320, sBy=180.
REQ-025 Reset asserted mid-frame SHALL abort the frame; counting SHALL restart at (0,0) on the first cycle after rst falls, and frame_start SHALL pulse one cycle later.

Configuration
REQ-026 With TRAIN_RENDER_COLLISION_EN defined, pixels inside both boxes SHALL be drawn FFF, and collision SHALL be set at the shadow latch when the boxes overlap and cleared at the next latch when they do not.
REQ-027 Without TRAIN_RENDER_COLLISION_EN, overlap pixels SHALL be drawn as train A (F00) and collision SHALL be tied to 0.

Verification
REQ-028 Release reset and run 420000 cycles -> exactly one frame_start; 525 hsync pulses, each 96 cycles low; vsync low for 1600 cycles.
REQ-029 With shadows at reset values, pixel (320,60) -> F00 and pixel (320,180) -> 00F; pixel (60,300) -> 888; pixel (10,10) -> 031; hcount 700 -> 000.
REQ-030 Change Ax from 320 to 330 mid-frame -> the current frame still draws A at 320; the next frame draws A at 330.
REQ-031 Set Ax=Bx=300 and Ay=By=300 with the macro defined -> pixel (300,300) is FFF and collision=1 after the latch; set By=400 -> collision=0 after the next latch.
REQ-032 Same stimulus as REQ-031 without the macro -> pixel (300,300) is F00 and collision stays 0.
REQ-033 Assert rst at hcount=400, vcount=200 for 3 cycles -> outputs match reset values; frame_start pulses one cycle after counting restarts from (0,0).
